// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types, plus the instruction-cache line geometry and FSM encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [2:0]   lc3b_word_sel;

    localparam int ICACHE_LINE_BYTES = 16;
    localparam int ICACHE_OFF_W      = $clog2(ICACHE_LINE_BYTES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } icache_state_e;

    function automatic lc3b_word line_word(input lc3b_line line, input lc3b_word_sel sel);
        return line[{sel, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped I-cache: one write port, combinational read.
module icache_array
    import lc3b_types::*;
#(
    parameter int sets = 8,
    localparam int IB = $clog2(sets),
    localparam int TW = 16 - ICACHE_OFF_W - IB
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [IB-1:0]  i_rd_index,
    output logic           o_rd_valid,
    output logic [TW-1:0]  o_rd_tag,
    output logic [127:0]   o_rd_line,
    input  logic           i_wr_en,
    input  logic [IB-1:0]  i_wr_index,
    input  logic [TW-1:0]  i_wr_tag,
    input  logic [127:0]   i_wr_line
);

    logic [sets-1:0] r_valid;
    logic [TW-1:0]   r_tag  [sets];
    lc3b_line        r_data [sets];

    // Only the valid bits are cleared; stale tags/data are masked by valid=0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_line;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_line  = r_data[i_rd_index];

endmodule

// File: rtl/l1_icache.sv
// Direct-mapped read-only L1 instruction cache: combinational hits, blocking line fills,
// saturating miss counter.
module l1_icache
    import lc3b_types::*;
#(
    parameter int sets = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [15:0]  instr_addr,
    input  logic         instr_read,
    output logic [15:0]  instr_rdata,
    output logic         instr_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  miss_count
);

    localparam int IB = $clog2(sets);
    localparam int LW = 16 - ICACHE_OFF_W;
    localparam int TW = LW - IB;

    icache_state_e r_state;
    logic [LW-1:0] r_fill_line;
    logic          r_pmem_read;
    logic [15:0]   r_miss_count;

    logic [IB-1:0] w_index;
    logic [TW-1:0] w_tag;
    lc3b_word_sel  w_word_sel;
    logic          w_rd_valid;
    logic [TW-1:0] w_rd_tag;
    lc3b_line      w_rd_line;
    logic          w_hit;
    logic          w_fill_done;
    logic          w_unused_addr0;

    assign w_index        = instr_addr[ICACHE_OFF_W +: IB];
    assign w_tag          = instr_addr[15 -: TW];
    assign w_word_sel     = instr_addr[3:1];
    assign w_unused_addr0 = instr_addr[0];

    icache_array #(.sets(sets)) u_array (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_rd_index (w_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_line  (w_rd_line),
        .i_wr_en    (w_fill_done),
        .i_wr_index (r_fill_line[IB-1:0]),
        .i_wr_tag   (r_fill_line[LW-1 -: TW]),
        .i_wr_line  (pmem_rdata)
    );

    assign w_hit       = instr_read & w_rd_valid & (w_rd_tag == w_tag);
    assign w_fill_done = (r_state == ST_FILL) & pmem_resp;

    // Hits are only reported from IDLE, so a fill and a hit never share a cycle.
    assign instr_resp   = reset_n & (r_state == ST_IDLE) & w_hit;
    assign instr_rdata  = line_word(w_rd_line, w_word_sel);
    assign pmem_read    = r_pmem_read;
    assign pmem_address = {r_fill_line, {ICACHE_OFF_W{1'b0}}};
    assign miss_count   = r_miss_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_fill_line  <= '0;
            r_pmem_read  <= 1'b0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_read && !w_hit) begin
                        r_state     <= ST_FILL;
                        r_fill_line <= instr_addr[15:ICACHE_OFF_W];
                        r_pmem_read <= 1'b1;
                        if (r_miss_count != 16'hFFFF) begin
                            r_miss_count <= r_miss_count + 16'd1;
                        end
                    end
                end
                // The latched line installs even if the core has redirected meanwhile.
                ST_FILL: begin
                    if (pmem_resp) begin
                        r_state     <= ST_IDLE;
                        r_pmem_read <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_pmem_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_icache.sv
// Randomised scoreboard bench for l1_icache with a line-level reference model and memory responder.
module tb_l1_icache;

    localparam int SETS = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [15:0]  instr_addr = '0;
    logic         instr_read = 1'b0;
    logic [15:0]  instr_rdata;
    logic         instr_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  miss_count;

    logic         mem_resp = 1'b0;
    logic [127:0] mem_line = '0;
    logic         spur_resp = 1'b0;
    logic [127:0] spur_line = '0;

    assign pmem_resp  = mem_resp | spur_resp;
    assign pmem_rdata = spur_resp ? spur_line : mem_line;

    l1_icache #(.sets(SETS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr_addr   (instr_addr),
        .instr_read   (instr_read),
        .instr_rdata  (instr_rdata),
        .instr_resp   (instr_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] cnt;
        int          kind;   // 0: no latency check, 1: same cycle as issue, 2: cycle after fill
        int          issue;
    } rsp_t;

    typedef struct {
        logic [15:0] addr;
        int          issue;  // -1: not checked
    } fill_t;

    rsp_t  sb_q[$];
    fill_t fill_q[$];

    int n_checks = 0;
    int n_pass = 0;
    int resp_seen = 0;
    int last_resp_cyc = -10;
    int fixed_lat = 0;

    // Reference model: which memory line each set holds, and the miss total.
    bit          mv[SETS];
    int          mres[SETS];
    logic [15:0] mcount = '0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'(a[15:1] * 16'h9E37) + 16'h1234;
    endfunction

    function automatic logic [127:0] build_line(input logic [15:0] la);
        logic [127:0] l;
        for (int i = 0; i < 8; i++) l[16*i +: 16] = mem_word(la + 16'(2 * i));
        return l;
    endfunction

    function automatic bit model_hit(input logic [15:0] a);
        int ln = int'(a >> 4);
        return mv[ln % SETS] && (mres[ln % SETS] == ln);
    endfunction

    function automatic bit model_access(input logic [15:0] a);
        int ln = int'(a >> 4);
        bit miss = !model_hit(a);
        if (miss) begin
            mv[ln % SETS] = 1'b1;
            mres[ln % SETS] = ln;
            if (mcount != 16'hFFFF) mcount = mcount + 16'd1;
        end
        return miss;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
        mcount = '0;
    endfunction

    // Memory responder: answers each line request after 1-4 cycles (or a fixed latency).
    initial begin
        logic [15:0] la;
        int lat;
        forever begin
            @(negedge clk);
            if (reset_n && pmem_read) begin
                la = pmem_address;
                lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
                repeat (lat) @(posedge clk);
                #1;
                mem_line = build_line(la);
                mem_resp = 1'b1;
                last_resp_cyc = cyc;
                @(posedge clk);
                #1;
                mem_resp = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT starts a fill or returns a word.
    initial begin
        bit    prev_pread;
        rsp_t  e;
        fill_t f;
        prev_pread = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (pmem_read && !prev_pread) begin
                    check("fill_expected", fill_q.size() != 0, 1);
                    if (fill_q.size() != 0) begin
                        f = fill_q.pop_front();
                        check("pmem_address", pmem_address, f.addr);
                        if (f.issue >= 0) check("fill_start_cycle", cyc, f.issue + 1);
                    end
                end
                if (instr_resp) begin
                    check("resp_expected", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("instr_rdata", instr_rdata, e.data);
                        check("miss_count", miss_count, e.cnt);
                        if (e.kind == 1) check("hit_latency", cyc, e.issue);
                        if (e.kind == 2) check("miss_latency", cyc, last_resp_cyc + 1);
                    end
                    resp_seen++;
                end
            end
            prev_pread = pmem_read;
        end
    end

    task automatic wait_resp(input string nm);
        int start = resp_seen;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            if (resp_seen != start) break;
        end
        #1;
        check({nm, "_responded"}, resp_seen != start, 1);
        if (resp_seen == start) begin
            sb_q.delete();
            fill_q.delete();
        end
    endtask

    task automatic fetch(input logic [15:0] a);
        bit   miss;
        rsp_t e;
        miss = model_access(a);
        if (miss) fill_q.push_back('{addr: a & 16'hFFF0, issue: cyc});
        e = '{addr: a, data: mem_word(a), cnt: mcount, kind: (miss ? 2 : 1), issue: cyc};
        sb_q.push_back(e);
        instr_addr = a;
        instr_read = 1'b1;
        wait_resp("fetch");
    endtask

    task automatic redirect(input logic [15:0] a, input logic [15:0] b);
        bit   miss_b;
        rsp_t e;
        void'(model_access(a));
        fill_q.push_back('{addr: a & 16'hFFF0, issue: cyc});
        instr_addr = a;
        instr_read = 1'b1;
        @(posedge clk);
        #1;
        instr_addr = b;
        miss_b = model_access(b);
        if (miss_b) fill_q.push_back('{addr: b & 16'hFFF0, issue: -1});
        e = '{addr: b, data: mem_word(b), cnt: mcount, kind: (miss_b ? 2 : 0), issue: -1};
        sb_q.push_back(e);
        wait_resp("redirect");
    endtask

    task automatic gap(input int n);
        instr_read = 1'b0;
        instr_addr = 16'($urandom);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                spur_line = {$urandom, $urandom, $urandom, $urandom};
                spur_resp = 1'b1;
            end
            @(posedge clk);
            #1;
            spur_resp = 1'b0;
            check("idle_pmem_read", pmem_read, 0);
        end
    endtask

    function automatic logic [15:0] rand_addr();
        return 16'({$urandom_range(0, 31), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))});
    endfunction

    initial begin
        logic [15:0] a;
        int r;
        model_reset();

        // Power-on reset
        #1 reset_n = 1'b0;
        instr_read = 1'b1;
        instr_addr = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr_resp", instr_resp, 0);
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_address", pmem_address, 16'h0000);
        check("rst_miss_count", miss_count, 16'h0000);
        instr_read = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss with a three-cycle memory, then every word of the line hits
        fixed_lat = 3;
        fetch(16'h0000);
        fixed_lat = 0;
        for (int w = 1; w < 8; w++) fetch(16'(2 * w));

        // Conflict on set 0
        fetch(16'h0080);
        fetch(16'h0000);
        check("conflict_miss_count", miss_count, 16'd3);

        // Redirect mid-fill: abandoned line still installs
        redirect(16'h0010, 16'h0020);
        fetch(16'h0010);
        gap(3);

        // Reset during a fill
        instr_addr = 16'h0030;
        instr_read = 1'b1;
        @(posedge clk);
        #1;
        check("fill_before_reset", pmem_read, 1);
        #1 reset_n = 1'b0;
        #1;
        check("reset_drops_pmem_read", pmem_read, 0);
        check("reset_instr_resp", instr_resp, 0);
        check("reset_miss_count", miss_count, 16'h0000);
        instr_read = 1'b0;
        model_reset();
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        fetch(16'h0000);

        // Random traffic
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 9));
            a = rand_addr();
            if (r < 7) fetch(a);
            else if (r < 8 && !model_hit(a)) redirect(a, rand_addr());
            else if (r < 8) fetch(a);
            else gap(int'($urandom_range(1, 3)));
        end

        // Saturation: preload the counter near its ceiling
        gap(1);
        force dut.r_miss_count = 16'hFFFD;
        @(posedge clk);
        #1;
        release dut.r_miss_count;
        @(posedge clk);
        #1;
        check("preload_miss_count", miss_count, 16'hFFFD);
        mcount = 16'hFFFD;
        fetch(16'h0F00);
        fetch(16'h0F10);
        fetch(16'h0F20);
        check("saturated_miss_count", miss_count, 16'hFFFF);

        gap(2);
        check("scoreboard_drained", sb_q.size(), 0);
        check("fills_drained", fill_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
